// File: rtl/reset_manager_pkg.sv
// Shared definitions for the reset manager: FSM encoding, cause bit layout,
// default timing constants and the debug view of internal state.
package reset_manager_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_STAGGER = 2'd2,
    ST_HALT    = 2'd3
  } rm_state_t;

  localparam int CAUSE_POR = 3;
  localparam int CAUSE_WDT = 2;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_BTN = 0;

  localparam int DEFAULT_ASSERT_CYCLES  = 16;
  localparam int DEFAULT_GAP_CYCLES     = 4;
  localparam int DEFAULT_ESCALATE_LIMIT = 3;
  localparam int BTN_FILTER_LEN         = 3;

  typedef struct packed {
    rm_state_t   state;
    logic [1:0]  esc;
  } rm_debug_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_manager_btn_filter.sv
// Push-button conditioning: 2-flop synchronizer followed by a run-length
// filter that emits a single-cycle pulse per press.
module btn_filter
  import reset_manager_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic btn_req,
  output logic btn_pulse
);

  logic [1:0] sync_q;
  logic [1:0] run_q, run_d;
  logic       fired_q, fired_d;
  logic       pulse_q, pulse_d;

  localparam logic [1:0] RUN_LAST = 2'(BTN_FILTER_LEN - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      run_q   <= 2'd0;
      fired_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_req};
      run_q   <= run_d;
      fired_q <= fired_d;
      pulse_q <= pulse_d;
    end
  end

  // A press only re-arms once a low synchronized sample has been seen.
  always_comb begin
    run_d   = run_q;
    fired_d = fired_q;
    pulse_d = 1'b0;
    if (!sync_q[1]) begin
      run_d   = 2'd0;
      fired_d = 1'b0;
    end else if (!fired_q) begin
      if (run_q == RUN_LAST) begin
        pulse_d = 1'b1;
        fired_d = 1'b1;
        run_d   = 2'd0;
      end else begin
        run_d = run_q + 2'd1;
      end
    end
  end

  assign btn_pulse = pulse_q;

endmodule

// File: rtl/reset_manager.sv
// Reset sequencer: collects reset requests, drives staggered cpu/peripheral/
// watchdog resets, records sticky causes and locks out on repeated watchdog hits.
module reset_manager
  import reset_manager_pkg::*;
#(
  parameter int ASSERT_CYCLES  = DEFAULT_ASSERT_CYCLES,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int ESCALATE_LIMIT = DEFAULT_ESCALATE_LIMIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wdt_req,
  input  logic       sw_req,
  input  logic       btn_req,
  input  logic       cause_clear,
  output logic       cpu_reset,
  output logic       periph_reset,
  output logic       wdt_reset,
  output logic [3:0] cause,
  output logic       halt,
  output logic       busy,
  output rm_debug_t  debug
);

  localparam int CNT_W = $clog2(max_int(ASSERT_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LAST_HOLD = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [1:0]       ESC_LIMIT = 2'(ESCALATE_LIMIT);

  logic [1:0]       rst_sync_q;
  rm_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       esc_q, esc_d;
  logic [3:0]       cause_q, cause_d, cause_new;
  logic             cpu_q, cpu_d, periph_q, periph_d, wdt_q, wdt_d;
  logic             halt_q, halt_d, busy_q, busy_d;
  logic             btn_pulse, req_any, rst_ok;

  btn_filter u_btn_filter (
    .clock     (clock),
    .reset     (reset),
    .btn_req   (btn_req),
    .btn_pulse (btn_pulse)
  );

  assign rst_ok  = rst_sync_q[1];
  assign req_any = wdt_req | sw_req | btn_pulse;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      esc_q      <= 2'd0;
      cause_q    <= 4'b1000;
      cpu_q      <= 1'b1;
      periph_q   <= 1'b1;
      wdt_q      <= 1'b1;
      halt_q     <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      esc_q      <= esc_d;
      cause_q    <= cause_d;
      cpu_q      <= cpu_d;
      periph_q   <= periph_d;
      wdt_q      <= wdt_d;
      halt_q     <= halt_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_RUN: begin
        if (req_any) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // The count stays parked until reset release has been synchronized.
        if (rst_ok) begin
          if (cnt_q == LAST_HOLD) begin
            state_d = (esc_q == ESC_LIMIT) ? ST_HALT : ST_STAGGER;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_STAGGER: begin
        if (cnt_q == LAST_GAP) state_d = ST_RUN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_HALT: begin
        if (cause_clear) state_d = ST_STAGGER;
      end
      default: state_d = ST_HOLD;
    endcase

    cause_new            = 4'b0000;
    cause_new[CAUSE_WDT] = wdt_req;
    cause_new[CAUSE_SW]  = sw_req;
    cause_new[CAUSE_BTN] = btn_pulse;
    cause_d = (cause_clear ? 4'b0000 : cause_q) | cause_new;

    // Any sw/btn involvement counts as a deliberate reset and clears escalation.
    esc_d = cause_clear ? 2'd0 : esc_q;
    if (state_q == ST_RUN && req_any) begin
      if (sw_req || btn_pulse) esc_d = 2'd0;
      else if (esc_d != 2'd3)  esc_d = esc_d + 2'd1;
    end
  end

  always_comb begin
    cpu_d    = (state_d != ST_RUN);
    periph_d = (state_d == ST_HOLD);
    wdt_d    = (state_d == ST_HOLD) || (state_d == ST_HALT);
    halt_d   = (state_d == ST_HALT);
    busy_d   = (state_d != ST_RUN);
  end

  assign cpu_reset    = cpu_q;
  assign periph_reset = periph_q;
  assign wdt_reset    = wdt_q;
  assign cause        = cause_q;
  assign halt         = halt_q;
  assign busy         = busy_q;
  assign debug.state  = state_q;
  assign debug.esc    = esc_q;

endmodule

// File: tb/tb_reset_manager.sv
// Directed bench for reset_manager: every output change is matched against a
// queue of hand-computed {cycles since previous change, output vector} entries.
module tb_reset_manager;
  import reset_manager_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wdt_req = 1'b0, sw_req = 1'b0, btn_req = 1'b0, cause_clear = 1'b0;
  logic       cpu_reset, periph_reset, wdt_reset, halt, busy;
  logic [3:0] cause;
  rm_debug_t  debug;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // entry = {gap[7:0], vec[10:0]}; gap 8'hFF means timing is not checked
  logic [18:0] exp_q[$];

  reset_manager dut (
    .clock        (clock),
    .reset        (reset),
    .wdt_req      (wdt_req),
    .sw_req       (sw_req),
    .btn_req      (btn_req),
    .cause_clear  (cause_clear),
    .cpu_reset    (cpu_reset),
    .periph_reset (periph_reset),
    .wdt_reset    (wdt_reset),
    .cause        (cause),
    .halt         (halt),
    .busy         (busy),
    .debug        (debug)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [10:0] mk(input logic c, input logic p, input logic w,
                                     input logic h, input logic b,
                                     input logic [3:0] ca, input logic [1:0] e);
    return {c, p, w, h, b, ca, e};
  endfunction

  task automatic expect_ev(input logic [10:0] v, input int gap);
    exp_q.push_back({8'(gap), v});
  endtask

  task automatic wait_neg(input int k);
    while (cyc < k) @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [10:0] cur, prev;
    logic [18:0] e;
    int          last_cyc;
    prev = 'x;
    last_cyc = 0;
    forever begin
      @(negedge clock);
      cur = {cpu_reset, periph_reset, wdt_reset, halt, busy, cause, debug.esc};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change: got %b at cycle %0d, nothing expected", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("vec@%0d", cyc), 32'(cur), 32'(e[10:0]));
          if (e[18:11] != 8'hFF)
            chk($sformatf("gap@%0d", cyc), 32'(cyc - last_cyc), 32'(e[18:11]));
        end
        prev = cur;
        last_cyc = cyc;
      end
    end
  end

  // stimulus
  initial begin
    // power-on reset and release
    expect_ev(mk(1,1,1,0,1,4'b1000,2'd0), 255);
    expect_ev(mk(1,0,0,0,1,4'b1000,2'd0), 19);
    expect_ev(mk(0,0,0,0,0,4'b1000,2'd0), 4);
    wait_neg(2);
    reset = 1'b1;

    // clear POR cause
    expect_ev(mk(0,0,0,0,0,4'b0000,2'd0), 7);
    wait_neg(30); cause_clear = 1'b1;
    wait_neg(31); cause_clear = 1'b0;

    // single 4-cycle watchdog pulse
    expect_ev(mk(1,1,1,0,1,4'b0100,2'd1), 5);
    expect_ev(mk(1,0,0,0,1,4'b0100,2'd1), 16);
    expect_ev(mk(0,0,0,0,0,4'b0100,2'd1), 4);
    wait_neg(35); wdt_req = 1'b1;
    wait_neg(39); wdt_req = 1'b0;

    // two more watchdog sequences escalate into HALT
    expect_ev(mk(1,1,1,0,1,4'b0100,2'd2), 5);
    expect_ev(mk(1,0,0,0,1,4'b0100,2'd2), 16);
    expect_ev(mk(0,0,0,0,0,4'b0100,2'd2), 4);
    wait_neg(60); wdt_req = 1'b1;
    wait_neg(64); wdt_req = 1'b0;
    expect_ev(mk(1,1,1,0,1,4'b0100,2'd3), 5);
    expect_ev(mk(1,0,1,1,1,4'b0100,2'd3), 16);
    wait_neg(85); wdt_req = 1'b1;
    wait_neg(89); wdt_req = 1'b0;

    // sw request in HALT only records cause; cause_clear releases
    expect_ev(mk(1,0,1,1,1,4'b0110,2'd3), 9);
    wait_neg(110); sw_req = 1'b1;
    wait_neg(111); sw_req = 1'b0;
    expect_ev(mk(1,0,0,0,1,4'b0000,2'd0), 10);
    expect_ev(mk(0,0,0,0,0,4'b0000,2'd0), 4);
    wait_neg(120); cause_clear = 1'b1;
    wait_neg(121); cause_clear = 1'b0;

    // short button press is filtered out, long press gives one sequence
    wait_neg(130); btn_req = 1'b1;
    wait_neg(132); btn_req = 1'b0;
    expect_ev(mk(1,1,1,0,1,4'b0001,2'd0), 21);
    expect_ev(mk(1,0,0,0,1,4'b0001,2'd0), 16);
    expect_ev(mk(0,0,0,0,0,4'b0001,2'd0), 4);
    wait_neg(140); btn_req = 1'b1;
    wait_neg(145); btn_req = 1'b0;

    // async reset in the middle of HOLD
    expect_ev(mk(1,1,1,0,1,4'b0011,2'd0), 5);
    expect_ev(mk(1,1,1,0,1,4'b1000,2'd0), 8);
    expect_ev(mk(1,0,0,0,1,4'b1000,2'd0), 21);
    expect_ev(mk(0,0,0,0,0,4'b1000,2'd0), 4);
    wait_neg(170); sw_req = 1'b1;
    wait_neg(171); sw_req = 1'b0;
    wait_neg(178);
    #2 reset = 1'b0;
    #1;
    chk("async_cpu", 32'(cpu_reset), 32'd1);
    chk("async_periph", 32'(periph_reset), 32'd1);
    chk("async_wdt", 32'(wdt_reset), 32'd1);
    chk("async_cause", 32'(cause), 32'h8);
    chk("async_halt_busy", 32'({halt, busy}), 32'b01);
    chk("async_state", 32'(debug.state), 32'(ST_HOLD));
    wait_neg(182); reset = 1'b1;

    // build cause 1100, then sw_req together with cause_clear
    expect_ev(mk(1,1,1,0,1,4'b1100,2'd1), 7);
    expect_ev(mk(1,0,0,0,1,4'b1100,2'd1), 16);
    expect_ev(mk(0,0,0,0,0,4'b1100,2'd1), 4);
    wait_neg(210); wdt_req = 1'b1;
    wait_neg(214); wdt_req = 1'b0;
    expect_ev(mk(1,1,1,0,1,4'b0010,2'd0), 10);
    expect_ev(mk(1,0,0,0,1,4'b0010,2'd0), 16);
    expect_ev(mk(0,0,0,0,0,4'b0010,2'd0), 4);
    wait_neg(240); sw_req = 1'b1; cause_clear = 1'b1;
    wait_neg(241); sw_req = 1'b0; cause_clear = 1'b0;

    // simultaneous watchdog + software request: one sequence, both causes
    expect_ev(mk(1,1,1,0,1,4'b0110,2'd0), 10);
    expect_ev(mk(1,0,0,0,1,4'b0110,2'd0), 16);
    expect_ev(mk(0,0,0,0,0,4'b0110,2'd0), 4);
    wait_neg(270); wdt_req = 1'b1; sw_req = 1'b1;
    wait_neg(271); sw_req = 1'b0;
    wait_neg(274); wdt_req = 1'b0;

    wait_neg(300);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
